// File: rtl/remote_comm_if.sv
// Host-side command/response link between the host logic and the remote_comm UART initiator.
interface remote_comm_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        busy;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;

  modport master (
    output cmd, snd_cmd, RX, clr_resp_rdy,
    input  cmd_snt, busy, TX, resp, resp_rdy
  );

  modport slave (
    input  cmd, snd_cmd, RX, clr_resp_rdy,
    output cmd_snt, busy, TX, resp, resp_rdy
  );
endinterface

// File: rtl/remote_comm.sv
// Host-side command initiator: sends a 16-bit command as two UART bytes (high first)
// and captures the single response byte returned by the robot.
module remote_comm #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic         clk,
  input  logic         rst,
  remote_comm_if.slave bus
);
  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] TX_IDLE    = 2'd0;
  localparam logic [1:0] TX_SEND_HI = 2'd1;
  localparam logic [1:0] TX_SEND_LO = 2'd2;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]  r_tx_state;
  logic [15:0] r_hold;
  logic [11:0] r_tx_cnt;
  logic [3:0]  r_tx_idx;
  logic        r_tx;
  logic        r_busy;
  logic        r_cmd_snt;
  logic [7:0]  w_tx_byte;
  logic [2:0]  w_bit_sel;
  logic        w_tx_bit;

  logic [1:0]  r_rx_state;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_prev;
  logic [11:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_resp;
  logic        r_resp_rdy;
  logic        w_fall;
  logic        w_rx_set;
  logic        w_rx_clr;

  assign w_tx_byte = (r_tx_state == TX_SEND_LO) ? r_hold[7:0] : r_hold[15:8];
  assign w_bit_sel = 3'(r_tx_idx - 4'd1);

  always_comb begin
    w_tx_bit = 1'b1;
    case (r_tx_idx)
      4'd0:    w_tx_bit = 1'b0;
      4'd9:    w_tx_bit = 1'b1;
      default: w_tx_bit = w_tx_byte[w_bit_sel];
    endcase
  end

  // Bit boundaries fall on the counter reaching zero; accept clears the counter so the
  // first boundary (start bit) is the very next edge. Index 10 marks "frame finished".
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_hold     <= '0;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_cmd_snt  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (bus.snd_cmd) begin
            r_hold     <= bus.cmd;
            r_cmd_snt  <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_state <= TX_SEND_HI;
          end
        end
        TX_SEND_HI, TX_SEND_LO: begin
          if (r_tx_cnt != 12'd0) begin
            r_tx_cnt <= r_tx_cnt - 12'd1;
          end else begin
            r_tx_cnt <= BAUD_LAST;
            if (r_tx_idx == 4'd10) begin
              if (r_tx_state == TX_SEND_HI) begin
                r_tx_state <= TX_SEND_LO;
                r_tx       <= 1'b0;
                r_tx_idx   <= 4'd1;
              end else begin
                r_tx_state <= TX_IDLE;
                r_tx       <= 1'b1;
                r_busy     <= 1'b0;
                r_cmd_snt  <= 1'b1;
                r_tx_idx   <= '0;
              end
            end else begin
              r_tx     <= w_tx_bit;
              r_tx_idx <= r_tx_idx + 4'd1;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign w_fall   = r_rx_prev & ~r_rx_s2;
  assign w_rx_set = (r_rx_state == RX_STOP) && (r_rx_cnt == 12'd0) && r_rx_s2;
  assign w_rx_clr = bus.clr_resp_rdy || ((r_rx_state == RX_IDLE) && w_fall);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_shift    <= '0;
      r_resp     <= '0;
      r_resp_rdy <= 1'b0;
    end else begin
      r_rx_s1   <= bus.RX;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_rx_cnt   <= BAUD_HALF;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt != 12'd0) begin
            r_rx_cnt <= r_rx_cnt - 12'd1;
          end else if (r_rx_s2) begin
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt   <= BAUD_LAST;
            r_rx_bit   <= '0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt != 12'd0) begin
            r_rx_cnt <= r_rx_cnt - 12'd1;
          end else begin
            r_shift  <= {r_rx_s2, r_shift[7:1]};
            r_rx_cnt <= BAUD_LAST;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt != 12'd0) r_rx_cnt   <= r_rx_cnt - 12'd1;
          else                   r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
      if (w_rx_set) r_resp <= r_shift;
      // A new byte outranks a same-cycle clear so it cannot be lost.
      if (w_rx_set)      r_resp_rdy <= 1'b1;
      else if (w_rx_clr) r_resp_rdy <= 1'b0;
    end
  end

  assign bus.TX       = r_tx;
  assign bus.busy     = r_busy;
  assign bus.cmd_snt  = r_cmd_snt;
  assign bus.resp     = r_resp;
  assign bus.resp_rdy = r_resp_rdy;
endmodule

// File: tb/tb_remote_comm.sv
// Scoreboarded bench for remote_comm: TX bytes and response bytes checked by independent monitors.
`timescale 1ns/1ps
module tb_remote_comm;
  localparam int unsigned B      = 16;
  localparam int unsigned TX_LAT = 1 + 20 * B;

  logic clk = 1'b0;
  logic rst = 1'b1;

  remote_comm_if bus();

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rsp_q[$];
  bit          tx_abort = 1'b0;
  bit          mon_en = 1'b0;
  logic [7:0]  resp_model = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Independent UART receiver on TX: samples mid-bit and compares against expected bytes.
  initial begin
    logic [9:0] fr;
    wait (mon_en);
    forever begin
      @(negedge bus.TX);
      tx_abort = 1'b0;
      repeat (B / 2) @(negedge clk);
      fr[0] = bus.TX;
      for (int j = 1; j < 10; j++) begin
        repeat (B) @(negedge clk);
        fr[j] = bus.TX;
      end
      if (!tx_abort) begin
        check("tx_start_bit", {31'd0, fr[0]}, 32'd0);
        check("tx_stop_bit", {31'd0, fr[9]}, 32'd1);
        if (tx_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_extra_byte: got %0h, expected no byte", fr[8:1]);
        end else begin
          check("tx_byte", {24'd0, fr[8:1]}, {24'd0, tx_q.pop_front()});
        end
      end
    end
  end

  // Response monitor: every rising resp_rdy must deliver the next expected byte.
  initial begin
    logic prev;
    prev = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (bus.resp_rdy && !prev) begin
        if (rsp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL resp_extra: got %0h, expected no response", bus.resp);
        end else begin
          check("resp_byte", {24'd0, bus.resp}, {24'd0, rsp_q.pop_front()});
        end
      end
      prev = bus.resp_rdy;
    end
  end

  task automatic issue(input logic [15:0] c);
    tx_q.push_back(c[15:8]);
    tx_q.push_back(c[7:0]);
    @(negedge clk);
    bus.cmd     = c;
    bus.snd_cmd = 1'b1;
    @(negedge clk);
    bus.snd_cmd = 1'b0;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    check("cmd_snt_after_accept", {31'd0, bus.cmd_snt}, 32'd0);
  endtask

  task automatic wait_done(input logic [15:0] poke_cmd, input int unsigned poke_at);
    int unsigned n;
    n = 0;
    while (!bus.cmd_snt && n < 1000) begin
      bus.snd_cmd = (poke_at != 0 && n == poke_at);
      if (poke_at != 0 && n == poke_at) bus.cmd = poke_cmd;
      @(negedge clk);
      n++;
    end
    check("tx_latency", n, TX_LAT);
    check("busy_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input bit clr_in_stop);
    if (stop) rsp_q.push_back(b);
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (B) @(negedge clk);
    end
    bus.RX = stop;
    if (clr_in_stop) bus.clr_resp_rdy = 1'b1;
    repeat (B) @(negedge clk);
    bus.RX = 1'b1;
    bus.clr_resp_rdy = 1'b0;
    if (stop) resp_model = b;
    check("resp_rdy_after_frame", {31'd0, bus.resp_rdy}, {31'd0, stop && !clr_in_stop});
    check("resp_after_frame", {24'd0, bus.resp}, {24'd0, resp_model});
  endtask

  task automatic clear_rdy();
    @(negedge clk);
    bus.clr_resp_rdy = 1'b1;
    @(negedge clk);
    bus.clr_resp_rdy = 1'b0;
    check("resp_rdy_cleared", {31'd0, bus.resp_rdy}, 32'd0);
  endtask

  initial begin
    logic [15:0] c;
    logic [15:0] c2;
    bus.cmd = '0;
    bus.snd_cmd = 1'b0;
    bus.RX = 1'b1;
    bus.clr_resp_rdy = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, bus.TX}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_cmd_snt", {31'd0, bus.cmd_snt}, 32'd0);
    check("rst_resp", {24'd0, bus.resp}, 32'd0);
    check("rst_resp_rdy", {31'd0, bus.resp_rdy}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    issue(16'h23FF);
    wait_done('0, 0);

    issue(16'h4002);
    wait_done(16'h0000, 100);
    repeat (2 * B) @(negedge clk);

    // Request on the completion edge is ignored; the next edge accepts it.
    c  = 16'($urandom);
    c2 = 16'($urandom);
    issue(c);
    wait_done(c2, TX_LAT - 1);
    tx_q.push_back(c2[15:8]);
    tx_q.push_back(c2[7:0]);
    @(negedge clk);
    bus.snd_cmd = 1'b0;
    check("busy_after_late_accept", {31'd0, bus.busy}, 32'd1);
    check("cmd_snt_after_late_accept", {31'd0, bus.cmd_snt}, 32'd0);
    wait_done('0, 0);

    send_rx(8'hA5, 1'b1, 1'b0);
    clear_rdy();
    send_rx(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (4) @(negedge clk);
    bus.RX = 1'b1;
    repeat (3 * B) @(negedge clk);
    check("glitch_resp_rdy", {31'd0, bus.resp_rdy}, 32'd0);
    check("glitch_resp", {24'd0, bus.resp}, {24'd0, resp_model});
    send_rx(8'h3C, 1'b1, 1'b1);

    issue(16'h6A17);
    repeat (50) @(negedge clk);
    tx_q.delete();
    tx_abort = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resp_model = 8'h00;
    check("midreset_tx", {31'd0, bus.TX}, 32'd1);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_cmd_snt", {31'd0, bus.cmd_snt}, 32'd0);
    check("midreset_resp", {24'd0, bus.resp}, 32'd0);
    repeat (12 * B) @(negedge clk);
    issue(16'h1E0F);
    wait_done('0, 0);

    for (int it = 0; it < 6; it++) begin
      logic [7:0] rb;
      logic       rs;
      c  = 16'($urandom);
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      fork
        begin
          issue(c);
          wait_done('0, 0);
        end
        send_rx(rb, rs, 1'b0);
      join
      clear_rdy();
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end

    for (int i = 0; i < 2000 && (tx_q.size() != 0 || rsp_q.size() != 0); i++) @(negedge clk);
    repeat (12 * B) @(negedge clk);
    check("tx_queue_drained", tx_q.size(), 32'd0);
    check("resp_queue_drained", rsp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
